// File: rtl/regfile4_onehot_if.sv
// Bus interface for regfile4_onehot.
// Groups the write port (we, one-hot selects D0..D3, wdata), the read port
// (re, ra0, ra1, rdata0, rdata1, rvalid) and the status outputs (err, wcount).
//   master : drives writes/reads, observes read data and status (bench / upstream)
//   slave  : the register file itself
interface regfile4_onehot_if #(
   parameter int WIDTH = 8
);
   logic             we;
   logic             D0;
   logic             D1;
   logic             D2;
   logic             D3;
   logic [WIDTH-1:0] wdata;
   logic             re;
   logic [1:0]       ra0;
   logic [1:0]       ra1;
   logic [WIDTH-1:0] rdata0;
   logic [WIDTH-1:0] rdata1;
   logic             rvalid;
   logic             err;
   logic [7:0]       wcount;

   modport master (
      output we, D0, D1, D2, D3, wdata, re, ra0, ra1,
      input  rdata0, rdata1, rvalid, err, wcount
   );

   modport slave (
      input  we, D0, D1, D2, D3, wdata, re, ra0, ra1,
      output rdata0, rdata1, rvalid, err, wcount
   );
endinterface

// File: rtl/regfile4_onehot.sv
// Four-entry register file written through one-hot selects D0..D3 (taken
// straight from a 2-to-4 decoder) with two registered read ports.
// Ports:
//   clk  - clock, all state updates on the rising edge
//   rst  - asynchronous, active-high reset
//   bus  - regfile4_onehot_if.slave: we, D0..D3, wdata, re, ra0, ra1 in;
//          rdata0, rdata1, rvalid, err (sticky illegal select), wcount out
// Build option:
//   RF_BYPASS_EN - when defined, a read port addressing the entry being
//                  written in the same cycle returns wdata instead of the
//                  old contents. Undefined by default (no forwarding).
module regfile4_onehot #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input logic               clk,
   input logic               rst,
   regfile4_onehot_if.slave  bus
);

`ifdef RF_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic [WIDTH-1:0] regs [4];
   logic [WIDTH-1:0] rdata0_q;
   logic [WIDTH-1:0] rdata1_q;
   logic             rvalid_q;
   logic             err_q;
   logic [7:0]       wcount_q;

   logic [3:0]       sel;
   logic [2:0]       sel_cnt;
   logic             wr_ok;
   logic             wr_bad;
   logic [1:0]       wr_idx;
   logic [WIDTH-1:0] rd_next0;
   logic [WIDTH-1:0] rd_next1;

   assign sel = {bus.D3, bus.D2, bus.D1, bus.D0};

   // Exactly one select high is the only legal write; zero or several is an error.
   always_comb begin
      sel_cnt = 3'(sel[0]) + 3'(sel[1]) + 3'(sel[2]) + 3'(sel[3]);
      wr_ok   = bus.we && (sel_cnt == 3'd1);
      wr_bad  = bus.we && (sel_cnt != 3'd1);
   end

   // Index encode; only used when sel is one-hot.
   always_comb begin
      wr_idx = 2'd0;
      if (sel[1]) wr_idx = 2'd1;
      if (sel[2]) wr_idx = 2'd2;
      if (sel[3]) wr_idx = 2'd3;
   end

   // Each read port forwards independently when bypass is built in.
   always_comb begin
      rd_next0 = regs[bus.ra0];
      rd_next1 = regs[bus.ra1];
      if (BYPASS && wr_ok && (wr_idx == bus.ra0)) rd_next0 = bus.wdata;
      if (BYPASS && wr_ok && (wr_idx == bus.ra1)) rd_next1 = bus.wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) regs[i] <= RESET_VAL;
         rdata0_q <= RESET_VAL;
         rdata1_q <= RESET_VAL;
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
         wcount_q <= 8'd0;
      end else begin
         if (wr_ok) begin
            regs[wr_idx] <= bus.wdata;
            wcount_q     <= wcount_q + 8'd1;
         end
         if (wr_bad) err_q <= 1'b1;
         rvalid_q <= bus.re;
         if (bus.re) begin
            rdata0_q <= rd_next0;
            rdata1_q <= rd_next1;
         end
      end
   end

   assign bus.rdata0 = rdata0_q;
   assign bus.rdata1 = rdata1_q;
   assign bus.rvalid = rvalid_q;
   assign bus.err    = err_q;
   assign bus.wcount = wcount_q;

endmodule

// File: tb/tb_regfile4_onehot.sv
// Directed bench for regfile4_onehot: writes driven through a 2-to-4 decoder
// model, illegal selects, same-cycle read/write, async reset and wcount wrap.
module tb_regfile4_onehot;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   regfile4_onehot_if #(.WIDTH(8)) bus ();

   regfile4_onehot #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.we = 1'b0; bus.D0 = 1'b0; bus.D1 = 1'b0; bus.D2 = 1'b0; bus.D3 = 1'b0;
      bus.wdata = 8'h00; bus.re = 1'b0; bus.ra0 = 2'd0; bus.ra1 = 2'd0;
   endtask

   // 2-to-4 decoder model: {A,B} selects D0..D3.
   task automatic drive_dec(input logic a, input logic b, input logic [7:0] d);
      logic [3:0] dec;
      dec = 4'b0001 << {a, b};
      bus.we = 1'b1;
      {bus.D3, bus.D2, bus.D1, bus.D0} = dec;
      bus.wdata = d;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      step(); step();
      n_tests++;
      if (bus.rvalid !== 1'b0 || bus.err !== 1'b0 || bus.wcount !== 8'd0 ||
          bus.rdata0 !== 8'h00 || bus.rdata1 !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_state rvalid=%b err=%b wcount=%0d rdata0=%h rdata1=%h, want 0 0 0 00 00",
                  bus.rvalid, bus.err, bus.wcount, bus.rdata0, bus.rdata1);
      end
      rst = 1'b0;
      bus.re = 1'b1; bus.ra0 = 2'd0; bus.ra1 = 2'd3;
      step();
      n_tests++;
      if (bus.rdata0 !== 8'h00 || bus.rdata1 !== 8'h00 || bus.rvalid !== 1'b1 ||
          bus.err !== 1'b0 || bus.wcount !== 8'd0) begin
         n_fail++;
         $display("FAIL first_read rdata0=%h rdata1=%h rvalid=%b err=%b wcount=%0d, want 00 00 1 0 0",
                  bus.rdata0, bus.rdata1, bus.rvalid, bus.err, bus.wcount);
      end
      bus.re = 1'b0;
      step();
      n_tests++;
      if (bus.rvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL rvalid_drop got %b want 0", bus.rvalid);
      end
   endtask

   task automatic test_decoder_writes();
      logic [7:0] exp_val [4];
      exp_val[0] = 8'h11; exp_val[1] = 8'h22; exp_val[2] = 8'h33; exp_val[3] = 8'h44;
      drive_dec(1'b0, 1'b0, 8'h11); step();
      drive_dec(1'b0, 1'b1, 8'h22); step();
      drive_dec(1'b1, 1'b0, 8'h33); step();
      drive_dec(1'b1, 1'b1, 8'h44); step();
      idle();
      n_tests++;
      if (bus.wcount !== 8'd4) begin
         n_fail++;
         $display("FAIL wcount_after_4 got %0d want 4", bus.wcount);
      end
      for (int i = 0; i < 4; i++) begin
         bus.re = 1'b1; bus.ra0 = 2'(i); bus.ra1 = 2'(3 - i);
         step();
         n_tests++;
         if (bus.rdata0 !== exp_val[i] || bus.rdata1 !== exp_val[3 - i] || bus.rvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL read_entry%0d rdata0=%h rdata1=%h rvalid=%b, want %h %h 1",
                     i, bus.rdata0, bus.rdata1, bus.rvalid, exp_val[i], exp_val[3 - i]);
         end
      end
      // Selects are don't-care while we=0.
      idle();
      bus.D0 = 1'b1; bus.D1 = 1'b1; bus.D2 = 1'b1; bus.D3 = 1'b1; bus.wdata = 8'hEE;
      step();
      idle();
      bus.re = 1'b1; bus.ra0 = 2'd1; bus.ra1 = 2'd2;
      step();
      n_tests++;
      if (bus.wcount !== 8'd4 || bus.err !== 1'b0 || bus.rdata0 !== 8'h22 || bus.rdata1 !== 8'h33) begin
         n_fail++;
         $display("FAIL we0_ignore wcount=%0d err=%b rdata0=%h rdata1=%h, want 4 0 22 33",
                  bus.wcount, bus.err, bus.rdata0, bus.rdata1);
      end
      idle();
   endtask

   task automatic test_illegal();
      bus.we = 1'b1; bus.D0 = 1'b1; bus.D2 = 1'b1; bus.wdata = 8'hFF;
      step();
      idle();
      n_tests++;
      if (bus.err !== 1'b1 || bus.wcount !== 8'd4) begin
         n_fail++;
         $display("FAIL illegal_two_hot err=%b wcount=%0d, want 1 4", bus.err, bus.wcount);
      end
      bus.re = 1'b1; bus.ra0 = 2'd0; bus.ra1 = 2'd2;
      step();
      n_tests++;
      if (bus.rdata0 !== 8'h11 || bus.rdata1 !== 8'h33) begin
         n_fail++;
         $display("FAIL illegal_no_write rdata0=%h rdata1=%h, want 11 33", bus.rdata0, bus.rdata1);
      end
      idle();
      bus.we = 1'b1; bus.wdata = 8'h77;   // zero-hot select
      step();
      drive_dec(1'b0, 1'b0, 8'h11);       // legal write afterwards
      step();
      idle();
      bus.re = 1'b1; bus.ra0 = 2'd0; bus.ra1 = 2'd1;
      step();
      n_tests++;
      if (bus.err !== 1'b1 || bus.wcount !== 8'd5 || bus.rdata0 !== 8'h11 || bus.rdata1 !== 8'h22) begin
         n_fail++;
         $display("FAIL err_sticky err=%b wcount=%0d rdata0=%h rdata1=%h, want 1 5 11 22",
                  bus.err, bus.wcount, bus.rdata0, bus.rdata1);
      end
      idle();
   endtask

   task automatic test_same_cycle();
      logic [7:0] exp0;
`ifdef RF_BYPASS_EN
      exp0 = 8'hA5;
`else
      exp0 = 8'h33;
`endif
      drive_dec(1'b1, 1'b0, 8'hA5);
      bus.re = 1'b1; bus.ra0 = 2'd2; bus.ra1 = 2'd1;
      step();
      n_tests++;
      if (bus.rdata0 !== exp0 || bus.rdata1 !== 8'h22 || bus.rvalid !== 1'b1 || bus.wcount !== 8'd6) begin
         n_fail++;
         $display("FAIL same_cycle rdata0=%h rdata1=%h rvalid=%b wcount=%0d, want %h 22 1 6",
                  bus.rdata0, bus.rdata1, bus.rvalid, bus.wcount, exp0);
      end
      idle();
      bus.re = 1'b1; bus.ra0 = 2'd2; bus.ra1 = 2'd2;
      step();
      n_tests++;
      if (bus.rdata0 !== 8'hA5 || bus.rdata1 !== 8'hA5 || bus.rvalid !== 1'b1) begin
         n_fail++;
         $display("FAIL after_write rdata0=%h rdata1=%h rvalid=%b, want a5 a5 1",
                  bus.rdata0, bus.rdata1, bus.rvalid);
      end
      bus.ra0 = 2'd3; bus.ra1 = 2'd0;
      step();
      n_tests++;
      if (bus.rdata0 !== 8'h44 || bus.rdata1 !== 8'h11 || bus.rvalid !== 1'b1) begin
         n_fail++;
         $display("FAIL back_to_back rdata0=%h rdata1=%h rvalid=%b, want 44 11 1",
                  bus.rdata0, bus.rdata1, bus.rvalid);
      end
      idle();
      step();
      n_tests++;
      if (bus.rdata0 !== 8'h44 || bus.rdata1 !== 8'h11 || bus.rvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL read_hold rdata0=%h rdata1=%h rvalid=%b, want 44 11 0",
                  bus.rdata0, bus.rdata1, bus.rvalid);
      end
   endtask

   task automatic test_async_reset();
      bus.re = 1'b1; bus.ra0 = 2'd2; bus.ra1 = 2'd3;
      drive_dec(1'b0, 1'b1, 8'h99);
      step();
      #2;
      rst = 1'b1;       // mid-cycle, no clock edge until well after the check
      #1;
      n_tests++;
      if (bus.rdata0 !== 8'h00 || bus.rdata1 !== 8'h00 || bus.rvalid !== 1'b0 ||
          bus.err !== 1'b0 || bus.wcount !== 8'd0) begin
         n_fail++;
         $display("FAIL async_reset rdata0=%h rdata1=%h rvalid=%b err=%b wcount=%0d, want 00 00 0 0 0",
                  bus.rdata0, bus.rdata1, bus.rvalid, bus.err, bus.wcount);
      end
      idle();
      step();
      rst = 1'b0;
      bus.re = 1'b1; bus.ra0 = 2'd0; bus.ra1 = 2'd1;
      step();
      n_tests++;
      if (bus.rdata0 !== 8'h00 || bus.rdata1 !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_entries01 rdata0=%h rdata1=%h, want 00 00", bus.rdata0, bus.rdata1);
      end
      bus.ra0 = 2'd2; bus.ra1 = 2'd3;
      step();
      n_tests++;
      if (bus.rdata0 !== 8'h00 || bus.rdata1 !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_entries23 rdata0=%h rdata1=%h, want 00 00", bus.rdata0, bus.rdata1);
      end
      idle();
   endtask

   task automatic test_wrap();
      logic [1:0] idx;
      for (int i = 0; i < 255; i++) begin
         idx = 2'(i);
         drive_dec(idx[1], idx[0], 8'(i));
         step();
      end
      idle();
      n_tests++;
      if (bus.wcount !== 8'd255) begin
         n_fail++;
         $display("FAIL wcount_255 got %0d want 255", bus.wcount);
      end
      drive_dec(1'b1, 1'b1, 8'h5A);
      step();
      n_tests++;
      if (bus.wcount !== 8'd0) begin
         n_fail++;
         $display("FAIL wcount_wrap_256 got %0d want 0", bus.wcount);
      end
      drive_dec(1'b0, 1'b0, 8'hC3);
      step();
      idle();
      n_tests++;
      if (bus.wcount !== 8'd1 || bus.err !== 1'b0) begin
         n_fail++;
         $display("FAIL wcount_257 wcount=%0d err=%b, want 1 0", bus.wcount, bus.err);
      end
      bus.re = 1'b1; bus.ra0 = 2'd0; bus.ra1 = 2'd3;
      step();
      n_tests++;
      if (bus.rdata0 !== 8'hC3 || bus.rdata1 !== 8'h5A) begin
         n_fail++;
         $display("FAIL wrap_data rdata0=%h rdata1=%h, want c3 5a", bus.rdata0, bus.rdata1);
      end
      idle();
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst     = 1'b1;
      idle();
      test_reset();
      test_decoder_writes();
      test_illegal();
      test_same_cycle();
      test_async_reset();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
